// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load-data formatting, writeback
// source select and retired-instruction counter.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_mem_valid,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic             i_mem_rd_wren,
  input  logic [1:0]       i_mem_wb_sel,
  input  logic [31:0]      i_mem_alu_result,
  input  logic [31:0]      i_mem_pc,
  input  logic [31:0]      i_mem_ld_data,
  input  logic [2:0]       i_mem_funct3,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_wren,
  output logic             o_wb_valid,
  output logic [31:0]      o_wb_pc,
  output logic [CNT_W-1:0] o_retired_count
);

  logic             valid_r;
  logic [4:0]       rd_addr_r;
  logic             rd_wren_r;
  logic [1:0]       wb_sel_r;
  logic [31:0]      alu_result_r;
  logic [31:0]      pc_r;
  logic [31:0]      ld_data_r;
  logic [2:0]       funct3_r;
  logic [CNT_W-1:0] retired_count_r;

  logic [31:0]      load_data_s;
  logic [31:0]      rd_data_s;

  // Misaligned halfwords never reach here, so off[0] is ignored for halves.
  function automatic logic [31:0] format_load(
    input logic [31:0] ld_data,
    input logic [2:0]  funct3,
    input logic [1:0]  off
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result_v;
    byte_v = ld_data[{off, 3'b000} +: 8];
    half_v = ld_data[{off[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  result_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  result_v = {{16{half_v[15]}}, half_v};
      3'b100:  result_v = {24'h000000, byte_v};
      3'b101:  result_v = {16'h0000, half_v};
      default: result_v = ld_data;
    endcase
    return result_v;
  endfunction

  // MEM/WB pipeline register; flush wins over stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_r      <= 1'b0;
      rd_addr_r    <= 5'd0;
      rd_wren_r    <= 1'b0;
      wb_sel_r     <= 2'b00;
      alu_result_r <= 32'h0000_0000;
      pc_r         <= 32'h0000_0000;
      ld_data_r    <= 32'h0000_0000;
      funct3_r     <= 3'b000;
    end else if (i_flush) begin
      valid_r      <= 1'b0;
      rd_addr_r    <= 5'd0;
      rd_wren_r    <= 1'b0;
      wb_sel_r     <= 2'b00;
      alu_result_r <= 32'h0000_0000;
      pc_r         <= 32'h0000_0000;
      ld_data_r    <= 32'h0000_0000;
      funct3_r     <= 3'b000;
    end else if (!i_stall) begin
      valid_r      <= i_mem_valid;
      rd_addr_r    <= i_mem_rd_addr;
      rd_wren_r    <= i_mem_rd_wren;
      wb_sel_r     <= i_mem_wb_sel;
      alu_result_r <= i_mem_alu_result;
      pc_r         <= i_mem_pc;
      ld_data_r    <= i_mem_ld_data;
      funct3_r     <= i_mem_funct3;
    end
  end

  // An instruction retires on the edge it leaves WB, so a stall keeps it from being counted twice.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      retired_count_r <= '0;
    end else if (valid_r && !i_stall) begin
      retired_count_r <= retired_count_r + CNT_W'(1);
    end
  end

  // Writeback source select from the registered fields only.
  always_comb begin
    load_data_s = format_load(ld_data_r, funct3_r, alu_result_r[1:0]);
    rd_data_s   = alu_result_r;
    case (wb_sel_r)
      2'b01:   rd_data_s = load_data_s;
      2'b10:   rd_data_s = pc_r + 32'd4;
      default: rd_data_s = alu_result_r;
    endcase
  end

  assign o_rd_addr       = rd_addr_r;
  assign o_rd_data       = rd_data_s;
  assign o_rd_wren       = valid_r & rd_wren_r & (rd_addr_r != 5'd0);
  assign o_wb_valid      = valid_r;
  assign o_wb_pc         = pc_r;
  assign o_retired_count = retired_count_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed and random-walk bench for wb_stage with a scoreboard of expected
// writeback outputs; CNT_W=4 so the counter wrap is reachable.
module tb_wb_stage;

  localparam int CNT_W = 4;

  logic             i_clk = 1'b0;
  logic             i_reset, i_stall, i_flush;
  logic             i_mem_valid;
  logic [4:0]       i_mem_rd_addr;
  logic             i_mem_rd_wren;
  logic [1:0]       i_mem_wb_sel;
  logic [31:0]      i_mem_alu_result, i_mem_pc, i_mem_ld_data;
  logic [2:0]       i_mem_funct3;
  logic [4:0]       o_rd_addr;
  logic [31:0]      o_rd_data;
  logic             o_rd_wren, o_wb_valid;
  logic [31:0]      o_wb_pc;
  logic [CNT_W-1:0] o_retired_count;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_mem_valid(i_mem_valid), .i_mem_rd_addr(i_mem_rd_addr),
    .i_mem_rd_wren(i_mem_rd_wren), .i_mem_wb_sel(i_mem_wb_sel),
    .i_mem_alu_result(i_mem_alu_result), .i_mem_pc(i_mem_pc),
    .i_mem_ld_data(i_mem_ld_data), .i_mem_funct3(i_mem_funct3),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren),
    .o_wb_valid(o_wb_valid), .o_wb_pc(o_wb_pc), .o_retired_count(o_retired_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic             valid;
    logic             wren;
    logic [4:0]       addr;
    logic [31:0]      data;
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;
    bit               fields_known;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference state of the stage as the bench expects it
  logic             m_valid = 1'b0, m_wren = 1'b0;
  logic [4:0]       m_rd = 5'd0;
  logic [31:0]      m_data = 32'h0, m_pc = 32'h0;
  logic [CNT_W-1:0] m_cnt = '0;
  bit               m_known = 1'b0;

  function automatic logic [31:0] ref_result(
    input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
    input logic [31:0] ld, input logic [2:0] f3);
    logic [31:0] bsh, hsh, fmt;
    bsh = ld >> (8 * alu[1:0]);
    hsh = alu[1] ? (ld >> 16) : ld;
    case (f3)
      3'b000:  fmt = {{24{bsh[7]}}, bsh[7:0]};
      3'b001:  fmt = {{16{hsh[15]}}, hsh[15:0]};
      3'b100:  fmt = bsh & 32'h0000_00FF;
      3'b101:  fmt = hsh & 32'h0000_FFFF;
      default: fmt = ld;
    endcase
    if (sel == 2'b01)      return fmt;
    else if (sel == 2'b10) return pc + 32'd4;
    else                   return alu;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] ld,
                       input logic [2:0] f3);
    i_mem_valid = v; i_mem_rd_addr = rd; i_mem_rd_wren = we; i_mem_wb_sel = sel;
    i_mem_alu_result = alu; i_mem_pc = pc; i_mem_ld_data = ld; i_mem_funct3 = f3;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1),
          2'($urandom), $urandom, $urandom, $urandom, 3'($urandom));
  endtask

  // One clock edge: predict, push, clock, pop and compare
  task automatic tick(input string tag, input bit rst, input bit st, input bit fl);
    exp_t e;
    if (rst) begin
      m_valid = 1'b0; m_wren = 1'b0; m_rd = 5'd0; m_data = 32'h0; m_pc = 32'h0;
      m_cnt = '0; m_known = 1'b1;
    end else begin
      if (m_valid && !st) m_cnt = m_cnt + 1'b1;
      if (fl) begin
        m_valid = 1'b0; m_wren = 1'b0; m_known = 1'b0;
      end else if (!st) begin
        m_valid = i_mem_valid; m_wren = i_mem_rd_wren; m_rd = i_mem_rd_addr;
        m_pc = i_mem_pc; m_known = 1'b1;
        m_data = ref_result(i_mem_wb_sel, i_mem_alu_result, i_mem_pc,
                            i_mem_ld_data, i_mem_funct3);
      end
    end
    e.valid = m_valid; e.wren = m_valid & m_wren & (m_rd != 5'd0);
    e.addr = m_rd; e.data = m_data; e.pc = m_pc; e.cnt = m_cnt;
    e.fields_known = m_known;
    sb.push_back(e);
    i_reset = rst; i_stall = st; i_flush = fl;
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    e = sb.pop_front();
    cmp({tag, ".valid"}, 32'(o_wb_valid), 32'(e.valid));
    cmp({tag, ".wren"},  32'(o_rd_wren),  32'(e.wren));
    cmp({tag, ".count"}, 32'(o_retired_count), 32'(e.cnt));
    if (e.fields_known) begin
      cmp({tag, ".addr"}, 32'(o_rd_addr), 32'(e.addr));
      cmp({tag, ".data"}, o_rd_data, e.data);
      cmp({tag, ".pc"},   o_wb_pc,   e.pc);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    drive_random();
    tick("reset0", 1'b1, 1'b0, 1'b0);
    drive_random();
    tick("reset1", 1'b1, 1'b0, 1'b0);
    cmp("reset_data", o_rd_data, 32'h0);
    cmp("reset_count", 32'(o_retired_count), 32'd0);

    // Load formatting
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h0000_1000, 32'h100, 32'h80F1_7F82, 3'b000);
    tick("lb_off0", 1'b0, 1'b0, 1'b0);
    cmp("lb_off0_const", o_rd_data, 32'hFFFF_FF82);
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h0000_1001, 32'h104, 32'h80F1_7F82, 3'b100);
    tick("lbu_off1", 1'b0, 1'b0, 1'b0);
    cmp("lbu_off1_const", o_rd_data, 32'h0000_007F);
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h0000_1002, 32'h108, 32'h80F1_7F82, 3'b001);
    tick("lh_off2", 1'b0, 1'b0, 1'b0);
    cmp("lh_off2_const", o_rd_data, 32'hFFFF_80F1);
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h0000_1002, 32'h10C, 32'h80F1_7F82, 3'b101);
    tick("lhu_off2", 1'b0, 1'b0, 1'b0);
    cmp("lhu_off2_const", o_rd_data, 32'h0000_80F1);
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h0000_1000, 32'h110, 32'h80F1_7F82, 3'b010);
    tick("lw", 1'b0, 1'b0, 1'b0);
    cmp("lw_const", o_rd_data, 32'h80F1_7F82);

    // Source select with PC+4 wrap
    drive(1'b1, 5'd4, 1'b1, 2'b10, 32'h0000_1234, 32'hFFFF_FFFC, 32'h0, 3'b010);
    tick("sel_pc4", 1'b0, 1'b0, 1'b0);
    cmp("sel_pc4_const", o_rd_data, 32'h0000_0000);
    drive(1'b1, 5'd4, 1'b1, 2'b00, 32'h0000_1234, 32'hFFFF_FFFC, 32'h0, 3'b010);
    tick("sel_alu", 1'b0, 1'b0, 1'b0);
    cmp("sel_alu_const", o_rd_data, 32'h0000_1234);
    drive(1'b1, 5'd4, 1'b1, 2'b11, 32'h0000_1234, 32'hFFFF_FFFC, 32'h0, 3'b010);
    tick("sel_11", 1'b0, 1'b0, 1'b0);
    cmp("sel_11_const", o_rd_data, 32'h0000_1234);

    // x0 suppression
    drive(1'b1, 5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h200, 32'h0, 3'b010);
    tick("x0", 1'b0, 1'b0, 1'b0);
    cmp("x0_wren_const", 32'(o_rd_wren), 32'd0);
    drive(1'b1, 5'd5, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h204, 32'h0, 3'b010);
    tick("x5", 1'b0, 1'b0, 1'b0);
    cmp("x5_wren_const", 32'(o_rd_wren), 32'd1);

    // Stall / flush
    tick("rst_stall_seq", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd7, 1'b1, 2'b00, 32'h0000_0777, 32'h300, 32'h0, 3'b010);
    tick("cap_rd7", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick("stall_hold", 1'b0, 1'b1, 1'b0);
    end
    cmp("stall_rd_addr_const", 32'(o_rd_addr), 32'd7);
    cmp("stall_count_const", 32'(o_retired_count), 32'd0);
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);
    tick("stall_release", 1'b0, 1'b0, 1'b0);
    cmp("release_count_const", 32'(o_retired_count), 32'd1);
    drive(1'b1, 5'd9, 1'b1, 2'b00, 32'h0000_0999, 32'h304, 32'h0, 3'b010);
    tick("cap_rd9", 1'b0, 1'b0, 1'b0);
    tick("flush_stall", 1'b0, 1'b1, 1'b1);
    cmp("flush_stall_valid_const", 32'(o_wb_valid), 32'd0);
    cmp("flush_stall_wren_const", 32'(o_rd_wren), 32'd0);
    drive(1'b1, 5'd10, 1'b1, 2'b00, 32'h0000_0AAA, 32'h308, 32'h0, 3'b010);
    tick("cap_rd10", 1'b0, 1'b0, 1'b0);
    tick("flush_departs", 1'b0, 1'b0, 1'b1);
    cmp("flush_counts_const", 32'(o_retired_count), 32'd2);

    // Random walk with occasional stalls and flushes
    for (int i = 0; i < 60; i++) begin
      drive_random();
      tick("rand", 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    // Reset wins over stall and flush
    drive_random();
    tick("rst_mid_stall", 1'b1, 1'b1, 1'b1);
    cmp("rst_mid_stall_pc_const", o_wb_pc, 32'h0);

    // Counter wrap: 17 retirements on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, 2'b00, 32'(i), 32'(4 * i), 32'h0, 3'b010);
      tick("wrap", 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);
    tick("wrap_drain", 1'b0, 1'b0, 1'b0);
    cmp("wrap_count_const", 32'(o_retired_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage RV32I pipeline. Holds the MEM/WB pipeline register, formats raw load data by size and byte offset, and selects the writeback source (ALU, load, PC+4). It drives the register file write port (address, data, enable) and supplies the same bus for WB→EX forwarding. It also keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32: width of retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_stall  in  1  hold MEM/WB register contents.
- i_flush  in  1  load a bubble into MEM/WB register.
- i_mem_valid  in  1  MEM stage holds a real instruction.
- i_mem_rd_addr  in  5  destination register.
- i_mem_rd_wren  in  1  instruction writes rd.
- i_mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- i_mem_alu_result  in  32  ALU result; also the load address.
- i_mem_pc  in  32  instruction PC.
- i_mem_ld_data  in  32  raw aligned word from the LSU.
- i_mem_funct3  in  3  load size/sign field.
- o_rd_addr  out  5  to regfile write address.
- o_rd_data  out  32  to regfile write data and forwarding.
- o_rd_wren  out  1  to regfile write enable.
- o_wb_valid  out  1  WB register holds a real instruction.
- o_wb_pc  out  32  PC of the WB instruction.
- o_retired_count  out  CNT_W  instructions retired since reset.

## Operation
- MEM/WB register fields: valid, rd_addr, rd_wren, wb_sel, alu_result, pc, ld_data, funct3.
- Update priority on each rising edge:
  - i_reset: clear all fields to 0 and clear the counter.
  - Else i_flush: valid=0 and rd_wren=0. Other fields are don't-care; clearing them is permitted.
  - Else i_stall: hold every field.
  - Else: capture all i_mem_* inputs.
- Load formatting is combinational from registered fields. off = alu_result[1:0]; byte = ld_data[8*off +: 8]; half = ld_data[16*off[1] +: 16], with off[0] ignored because misalignment is trapped upstream.
  - funct3 000 LB: sign-extend byte.
  - funct3 001 LH: sign-extend half.
  - funct3 010 LW: full word.
  - funct3 100 LBU: zero-extend byte.
  - funct3 101 LHU: zero-extend half.
  - funct3 011, 110, 111: full word.
- o_rd_data: wb_sel 01 gives the formatted load; 10 gives pc+4 (32-bit, wraps); 00 and 11 give alu_result.
- o_rd_wren = valid & rd_wren & (rd_addr != 0). o_rd_addr = registered rd_addr.
- o_wb_valid = registered valid. o_wb_pc = registered pc.
- Retire counter: increments by 1 on an edge where valid=1 and i_stall=0 and i_reset=0. An instruction is counted once no matter how long it is stalled. A flush on the same edge still counts the departing instruction. Wraps modulo 2^CNT_W.

## Timing
- Latency: 1 cycle. MEM inputs sampled at edge N appear on o_rd_* after edge N, and the regfile commits them at edge N+1.
- After reset all outputs are 0: o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_wb_valid=0, o_wb_pc=0, o_retired_count=0.
- Reset asserted mid-stall or mid-flush wins on that edge. Outputs are 0 the cycle after.
- During a stall, o_rd_* stay constant and may stay asserted. The repeated regfile write of the same value is intended.
- i_flush and i_stall together: the flush wins and a bubble is loaded.
- No combinational path from i_mem_* to any output.

## Test plan
- Reset: hold i_reset 2 cycles with random inputs. All outputs 0; counter 0.
- Load formatting: ld_data=0x80F17F82, funct3=000, off=0 gives 0xFFFFFF82; funct3=100, off=1 gives 0x0000007F; funct3=001, off=2 gives 0xFFFF80F1; funct3=101, off=2 gives 0x000080F1; funct3=010 gives 0x80F17F82.
- Source select: alu_result=0x1234, pc=0xFFFFFFFC. wb_sel=10 gives o_rd_data=0x00000000; wb_sel=00 and 11 give 0x00001234.
- x0 suppression: rd_addr=0, rd_wren=1, valid=1 gives o_rd_wren=0. rd_addr=5 gives o_rd_wren=1 one cycle after capture.
- Stall/flush: capture a valid instruction (rd=7), stall 3 cycles. o_rd_* hold and the counter stays at 0. Release the stall: counter becomes 1. A flush with a stall loads a bubble: o_wb_valid=0, o_rd_wren=0.
- Counter wrap with CNT_W=4: retire 17 valid instructions with no stalls. o_retired_count=1.
